adder_rr_scheduler: RTL and testbench

Shares one W-bit ripple-carry adder among N_REQ requesters. Each requester offers an operand set (A, B, Cin) on a valid/ready handshake. A round-robin arbiter grants one request at a time. The shared adder result is returned on a single response channel, tagged with the requester ID. The block sits between the tile's operand sources and the adder datapath and replaces direct per-source adder instances.

---
 rtl/adder_sched_pkg.sv | 12 +
 rtl/rca_w.sv | 21 ++
 rtl/adder_rr_scheduler.sv | 131 +++++++++++++
 tb/tb_adder_rr_scheduler.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// Shared types and constants for the round-robin shared-adder scheduler.
package adder_sched_pkg;
  localparam int ADDER_W_DEF = 3;
  localparam int N_REQ_DEF   = 4;
  localparam int OP_CNT_W    = 10;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    RESPOND
  } state_t;
endpackage

// File: rtl/rca_w.sv
// Parameterised W-bit ripple-carry adder: a chain of one-bit full-adder cells.
module rca_w #(
  parameter int W = 3
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];
endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one rca_w adder among N_REQ requesters.
// Optional ADDER_SCHED_STATS_EN adds the op_count handshake counter output.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter  int N_REQ = N_REQ_DEF,
  parameter  int W     = ADDER_W_DEF,
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ-1:0]   req_cin,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [W-1:0]       rsp_sum,
  output logic               rsp_cout,
`ifdef ADDER_SCHED_STATS_EN
  output logic [IDW-1:0]     rsp_id,
  output logic [OP_CNT_W-1:0] op_count
`else
  output logic [IDW-1:0]     rsp_id
`endif
);

  // First valid index scanning upward from last+1, wrapping at N_REQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] v,
                                             input logic [IDW-1:0]   last);
    logic [IDW-1:0]   pick;
    logic             found;
    logic [N_REQ-1:0] tmp;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      tmp = v >> idx;
      if (!found && tmp[0]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
    return pick;
  endfunction

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_grant_q;
  logic [IDW-1:0]   grant_id;
  logic             accept;
  logic [N_REQ-1:0] cin_sel;

  logic [W-1:0]     a_p0, b_p0;
  logic             cin_p0;
  logic [IDW-1:0]   id_p0;
  logic [W-1:0]     sum_c;
  logic             cout_c;

  assign grant_id = rr_pick(req_valid, last_grant_q);
  assign cin_sel  = req_cin >> grant_id;

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready is withheld while reset is asserted so it shows its reset value.
        if (rst && (|req_valid)) begin
          req_ready = N_REQ'(1) << grant_id;
          accept    = 1'b1;
          state_d   = COMPUTE;
        end
      end
      COMPUTE: state_d = RESPOND;
      RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(N_REQ - 1);
      rsp_sum      <= '0;
      rsp_cout     <= 1'b0;
      rsp_id       <= '0;
    end else begin
      state_q <= state_d;
      if (accept) last_grant_q <= grant_id;
      // p0 -> p1: adder result becomes the held response
      if (state_q == COMPUTE) begin
        rsp_sum  <= sum_c;
        rsp_cout <= cout_c;
        rsp_id   <= id_p0;
      end
    end
  end

  // p0: operands of the granted requester, captured at the request handshake
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= W'(req_a >> (int'(grant_id) * W));
      b_p0   <= W'(req_b >> (int'(grant_id) * W));
      cin_p0 <= cin_sel[0];
      id_p0  <= grant_id;
    end
  end

  rca_w #(.W(W)) u_rca (
    .a    (a_p0),
    .b    (b_p0),
    .cin  (cin_p0),
    .sum  (sum_c),
    .cout (cout_c)
  );

`ifdef ADDER_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) op_count <= '0;
    else if (rsp_valid && rsp_ready) op_count <= op_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Self-checking bench for adder_rr_scheduler: per-cycle model compare plus directed literal checks.
module tb_adder_rr_scheduler;
  localparam int N    = 4;
  localparam int W    = 3;
  localparam int IDW  = 2;
  localparam int MASK = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_cin = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;
  logic [IDW-1:0] rsp_id;
`ifdef ADDER_SCHED_STATS_EN
  logic [9:0]     op_count;
`endif

  always #5 clk = ~clk;

  adder_rr_scheduler #(.N_REQ(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
`ifdef ADDER_SCHED_STATS_EN
    .rsp_id    (rsp_id),
    .op_count  (op_count)
`else
    .rsp_id    (rsp_id)
`endif
  );

  int chk  = 0;
  int errs = 0;
  int cyc  = 0;

  int g_id[$], g_cyc[$];
  int r_sum[$], r_cout[$], r_id[$], r_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Requester served next: first valid one after the last served, wrapping.
  function automatic int rr_winner(input logic [N-1:0] v, input int last);
    int vi;
    vi = int'(v);
    for (int k = 1; k <= N; k++) begin
      if (((vi >> ((last + k) % N)) & 1) != 0) return (last + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: busy from accept until response handshake; response visible 2 edges after accept.
  bit m_init = 0;
  bit m_busy = 0;
  int m_age = 0;
  int m_last = N - 1;
  int m_sum = 0, m_cout = 0, m_id = 0;
  int p_sum = 0, p_cout = 0, p_id = 0;

  always @(negedge clk) begin
    int w;
    int s;
    logic [N-1:0] exp_ready;
    if (m_init) begin
      exp_ready = '0;
      if (rst && !m_busy) begin
        w = rr_winner(req_valid, m_last);
        if (w >= 0) exp_ready = N'(1) << w;
      end
      check("req_ready", req_ready, exp_ready);
      check("rsp_valid", rsp_valid, m_busy && (m_age >= 2));
      check("rsp_sum", rsp_sum, m_sum);
      check("rsp_cout", rsp_cout, m_cout);
      check("rsp_id", rsp_id, m_id);
    end
    if (rst && ((req_ready & req_valid) != 0)) begin
      g_id.push_back($clog2(int'(req_ready)));
      g_cyc.push_back(cyc + 1);
    end
    if (rst && rsp_valid && rsp_ready) begin
      r_sum.push_back(int'(rsp_sum));
      r_cout.push_back(int'(rsp_cout));
      r_id.push_back(int'(rsp_id));
      r_cyc.push_back(cyc + 1);
    end
    if (!rst) begin
      m_init = 1; m_busy = 0; m_age = 0; m_last = N - 1;
      m_sum = 0; m_cout = 0; m_id = 0;
    end else if (m_init) begin
      if (!m_busy) begin
        w = rr_winner(req_valid, m_last);
        if (w >= 0) begin
          s = (int'(req_a >> (w * W)) & MASK) + (int'(req_b >> (w * W)) & MASK)
              + (int'(req_cin >> w) & 1);
          p_sum = s % (1 << W);
          p_cout = (s >> W) & 1;
          p_id = w;
          m_last = w;
          m_busy = 1;
          m_age = 1;
        end
      end else if (m_age == 1) begin
        m_age = 2;
        m_sum = p_sum; m_cout = p_cout; m_id = p_id;
      end else if (rsp_ready) begin
        m_busy = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_op(input int i, input int a, input int b, input int c);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_cin[i]      = c[0];
  endtask

  task automatic clear_logs();
    g_id.delete(); g_cyc.delete();
    r_sum.delete(); r_cout.delete(); r_id.delete(); r_cyc.delete();
  endtask

  initial begin
    int order[6];
    order = '{0, 1, 2, 3, 0, 1};

    // Reset with every requester asking
    rst = 1'b0; req_valid = '1; rsp_ready = 1'b1;
    tick(3);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_rsp_id", rsp_id, 0);
    req_valid = '0; rst = 1'b1;
    tick(1);

    // Single request: 5+6+1 = 12 -> sum 4, cout 1
    clear_logs();
    set_op(2, 5, 6, 1);
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    tick(4);
    check("single_ngrant", g_id.size(), 1);
    check("single_nrsp", r_sum.size(), 1);
    if (g_id.size() == 1 && r_sum.size() == 1) begin
      check("single_grant_id", g_id[0], 2);
      check("single_sum", r_sum[0], 4);
      check("single_cout", r_cout[0], 1);
      check("single_rsp_id", r_id[0], 2);
      check("single_latency", r_cyc[0] - g_cyc[0], 2);
    end

    // Full-scale operands: 7+7+1 = 15 -> sum 7, cout 1
    clear_logs();
    set_op(3, 7, 7, 1);
    req_valid = 4'b1000;
    tick(1);
    req_valid = '0;
    tick(4);
    check("max_nrsp", r_sum.size(), 1);
    if (r_sum.size() == 1) begin
      check("max_sum", r_sum[0], 7);
      check("max_cout", r_cout[0], 1);
      check("max_id", r_id[0], 3);
    end

    // Round-robin with all requesters valid continuously
    clear_logs();
    set_op(0, 1, 2, 0);
    set_op(1, 3, 4, 1);
    set_op(2, 6, 5, 0);
    set_op(3, 2, 2, 1);
    req_valid = '1;
    tick(18);
    req_valid = '0;
    tick(4);
    check("rr_ngrant", g_id.size(), 6);
    check("rr_nrsp", r_sum.size(), 6);
    if (g_id.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        check("rr_order", g_id[k], order[k]);
        if (k > 0) check("rr_spacing", g_cyc[k] - g_cyc[k-1], 3);
      end
    end
    if (r_sum.size() == 6) begin
      check("rr_sum_req2", r_sum[2], 3);
      check("rr_cout_req2", r_cout[2], 1);
    end

    // Backpressure: response held 10 cycles while others wait
    clear_logs();
    rsp_ready = 1'b0;
    set_op(0, 4, 3, 0);
    req_valid = 4'b0001;
    tick(1);
    req_valid = '1;
    tick(1);
    for (int k = 0; k < 10; k++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_sum", rsp_sum, 7);
      check("bp_rsp_cout", rsp_cout, 0);
      check("bp_req_ready", req_ready, 0);
      tick(1);
    end
    rsp_ready = 1'b1;
    tick(2);
    req_valid = '0;
    tick(4);
    check("bp_ngrant", g_id.size(), 2);
    check("bp_nrsp", r_sum.size(), 2);
    if (g_id.size() == 2 && r_sum.size() == 2) begin
      check("bp_next_id", g_id[1], 1);
      check("bp_next_gap", g_cyc[1] - r_cyc[0], 1);
      check("bp_second_sum", r_sum[1], 0);
      check("bp_second_cout", r_cout[1], 1);
    end

    // Reset while the accepted operation is in COMPUTE
    clear_logs();
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(5);
    check("midrst_nrsp", r_sum.size(), 0);
    check("midrst_valid", rsp_valid, 0);
    req_valid = '1;
    tick(1);
    req_valid = '0;
    tick(4);
    check("midrst_ngrant", g_id.size(), 2);
    check("midrst_nrsp2", r_sum.size(), 1);
    if (g_id.size() == 2 && r_sum.size() == 1) begin
      check("midrst_first_id", g_id[1], 0);
      check("midrst_rsp_id", r_id[0], 0);
    end

`ifdef ADDER_SCHED_STATS_EN
    // 1025 handshakes from reset wrap the 10-bit counter to 1
    rst = 1'b0;
    tick(1);
    check("stats_reset", op_count, 0);
    rst = 1'b1;
    req_valid = '1;
    tick(3075);
    req_valid = '0;
    tick(2);
    check("stats_wrap", op_count, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end
endmodule
